spi_regbus_bridge: RTL and testbench

- SPI-slave front end that turns host SPI frames into single-cycle register-bus transactions for the slot/GPIO/SPI-master register bank.
- Sits directly upstream of the register bank; all logic runs in the sys_clk domain and oversamples the SPI pins.
- Frame format: ADDR_W address bits (MSB first, MSB = read flag), DUMMY_CYCLES idle clocks, then DATA_W data bits (MSB first).

---
 rtl/spi_regbus_bridge_pkg.sv | 22 ++
 rtl/spi_regbus_bridge_if.sv | 32 +++
 rtl/spi_regbus_bridge_pin_sync.sv | 48 ++++
 rtl/spi_regbus_bridge.sv | 239 +++++++++++++++++++++++
 tb/tb_spi_regbus_bridge.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_regbus_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DUMMY,
    DATA,
    DONE
  } state_t;

  localparam int PKG_ADDR_W      = 8;
  localparam int READ_FLAG_BIT   = PKG_ADDR_W - 1;
  localparam int MIN_HALF_PERIOD = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_regbus_bridge_if.sv
// Register-bus side of the bridge: single-cycle write/read strobes plus read return.
interface spi_regbus_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic [ADDR_W-2:0] bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;

  modport master (
    output bus_addr,
    output bus_we,
    output bus_wdata,
    output bus_re,
    input  bus_rdata,
    input  bus_rvalid
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_wdata,
    input  bus_re,
    output bus_rdata,
    output bus_rvalid
  );

endinterface

// File: rtl/spi_regbus_bridge_pin_sync.sv
// Synchronizes the raw SPI pins into sys_clk and derives spi_clk edge pulses.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic spi_clk,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  output logic clk_rise,
  output logic clk_fall,
  output logic cs_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   clk_prev_q, clk_prev_d;

  always_comb begin
    clk_sync_d  = SYNC_STAGES'({clk_sync_q, spi_clk});
    cs_sync_d   = SYNC_STAGES'({cs_sync_q, spi_cs_n});
    mosi_sync_d = SYNC_STAGES'({mosi_sync_q, spi_mosi});
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

  // mosi_s comes out of the same depth of chain as the clock, so it lines up with clk_rise.
  assign clk_rise = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
  assign clk_fall = ~clk_sync_q[SYNC_STAGES-1] & clk_prev_q;
  assign cs_n_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regbus_bridge.sv
// SPI-slave to register-bus bridge. Optional 8-bit saturating error counter
// port err_cnt is built when SPI_BRIDGE_ERR_CNT_EN is defined.
module spi_regbus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int DUMMY_CYCLES = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                spi_clk,
  input  logic                spi_cs_n,
  input  logic                spi_mosi,
  output logic                spi_miso,
  spi_regbus_bridge_if.master bus,
  output logic                frame_err
`ifdef SPI_BRIDGE_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int CNT_W = $clog2(max3(ADDR_W, DUMMY_CYCLES, DATA_W) + 1);

  logic clk_rise, cs_n_s, mosi_s;
  logic clk_fall_unused;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .spi_clk  (spi_clk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .clk_rise (clk_rise),
    .clk_fall (clk_fall_unused),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-2:0] addr_sr_q, addr_sr_d;
  logic [ADDR_W-2:0] addr_q, addr_d;
  logic              is_read_q, is_read_d;
  logic [DATA_W-2:0] wr_sr_q, wr_sr_d;
  logic [DATA_W-1:0] rd_sr_q, rd_sr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_ok_q, rd_ok_d;
  logic              miso_q, miso_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic              cs_n_prev_q, cs_n_prev_d;
  logic [ADDR_W-1:0] addr_shift;
  logic [DATA_W-1:0] wr_word;

  assign addr_shift = {addr_sr_q, mosi_s};
  assign wr_word    = {wr_sr_q, mosi_s};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_sr_d   = addr_sr_q;
    addr_d      = addr_q;
    is_read_d   = is_read_q;
    wr_sr_d     = wr_sr_q;
    rd_sr_d     = rd_sr_q;
    wdata_d     = wdata_q;
    rd_ok_d     = rd_ok_q;
    miso_d      = miso_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    err_d       = 1'b0;
    cs_n_prev_d = cs_n_s;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        // Only a falling cs_n edge starts a frame, so a cs_n held low across reset is not mistaken for one.
        if (cs_n_prev_q && !cs_n_s) begin
          state_d   = ADDR;
          cnt_d     = '0;
          addr_sr_d = '0;
          wr_sr_d   = '0;
          rd_sr_d   = '0;
          rd_ok_d   = 1'b0;
          is_read_d = 1'b0;
        end
      end

      ADDR: begin
        miso_d = 1'b0;
        if (cs_n_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (clk_rise) begin
          addr_sr_d = addr_shift[ADDR_W-2:0];
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            is_read_d = addr_shift[ADDR_W-1];
            addr_d    = addr_shift[ADDR_W-2:0];
            re_d      = addr_shift[ADDR_W-1];
            cnt_d     = '0;
            state_d   = DUMMY;
          end
        end
      end

      DUMMY: begin
        if (cs_n_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else begin
          if (bus.bus_rvalid && is_read_q && !rd_ok_q) begin
            rd_sr_d = bus.bus_rdata;
            rd_ok_d = 1'b1;
          end
          if (clk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = DATA;
              // Data that has not arrived by the last turnaround clock is treated as late.
              if (is_read_q && !rd_ok_q) begin
                rd_sr_d = '0;
                miso_d  = 1'b0;
                err_d   = 1'b1;
              end else begin
                miso_d = rd_sr_q[DATA_W-1];
              end
            end
          end
        end
      end

      DATA: begin
        if (cs_n_s) begin
          state_d = IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else if (clk_rise) begin
          wr_sr_d = wr_word[DATA_W-2:0];
          rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
          miso_d  = rd_sr_q[DATA_W-2];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d   = '0;
            state_d = DONE;
            miso_d  = 1'b0;
            if (!is_read_q) begin
              we_d    = 1'b1;
              wdata_d = wr_word;
            end
          end
        end
      end

      DONE: begin
        miso_d = 1'b0;
        if (cs_n_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_sr_q   <= '0;
      addr_q      <= '0;
      is_read_q   <= 1'b0;
      wr_sr_q     <= '0;
      rd_sr_q     <= '0;
      wdata_q     <= '0;
      rd_ok_q     <= 1'b0;
      miso_q      <= 1'b0;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cs_n_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_sr_q   <= addr_sr_d;
      addr_q      <= addr_d;
      is_read_q   <= is_read_d;
      wr_sr_q     <= wr_sr_d;
      rd_sr_q     <= rd_sr_d;
      wdata_q     <= wdata_d;
      rd_ok_q     <= rd_ok_d;
      miso_q      <= miso_d;
      re_q        <= re_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cs_n_prev_q <= cs_n_prev_d;
    end
  end

  assign spi_miso      = miso_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_re    = re_q;

`ifdef SPI_BRIDGE_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign frame_err = err_q;
`else
  assign frame_err = err_q;
`endif

endmodule

// File: tb/tb_spi_regbus_bridge.sv
// Scoreboard bench for spi_regbus_bridge: a bit-banged SPI host, a register-bank model and a monitor.
module tb_spi_regbus_bridge;
  import spi_bridge_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int DUMMY_N = 8;
  localparam int CLK_P   = 10;
  localparam int HALF    = 2 * MIN_HALF_PERIOD * CLK_P;

  typedef struct {
    logic [ADDR_W-2:0] addr;
    logic [DATA_W-1:0] data;
  } we_exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic spi_clk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso;
  logic frame_err;
`ifdef SPI_BRIDGE_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad = 0;
  int re_seen = 0;
  int err_seen = 0;
  int rv_delay = 2;
  bit withhold = 1'b0;

  we_exp_t           exp_we[$];
  logic [DATA_W-1:0] exp_rd[$];
  logic [DATA_W-1:0] rd_got[$];
  logic [DATA_W-1:0] mem [0:127];

  spi_regbus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  spi_regbus_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DUMMY_CYCLES(DUMMY_N), .SYNC_STAGES(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .bus       (bus_if),
    .frame_err (frame_err)
`ifdef SPI_BRIDGE_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #(CLK_P / 2) sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Bit-banged mode-0 host; edges land on sys_clk falling edges.
  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                               input int n_dummy, input int n_data, input bit release_cs,
                               output logic [DATA_W-1:0] rdata);
    rdata = '0;
    @(negedge sys_clk);
    spi_cs_n = 1'b0;
    #(HALF);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      spi_mosi = addr[i];
      #(HALF); spi_clk = 1'b1;
      #(HALF); spi_clk = 1'b0;
    end
    spi_mosi = 1'b0;
    for (int i = 0; i < n_dummy; i++) begin
      #(HALF); spi_clk = 1'b1;
      #(HALF); spi_clk = 1'b0;
    end
    for (int i = 0; i < n_data; i++) begin
      spi_mosi = wdata[DATA_W-1-i];
      #(HALF);
      rdata = {rdata[DATA_W-2:0], spi_miso};
      spi_clk = 1'b1;
      #(HALF); spi_clk = 1'b0;
    end
    #(HALF);
    if (release_cs) begin
      spi_cs_n = 1'b1;
      #(HALF);
    end
  endtask

  task automatic doWrite(input logic [ADDR_W-2:0] a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    exp_we.push_back('{addr: a, data: d});
    applyStimulus({1'b0, a}, d, DUMMY_N, DATA_W, 1'b1, r);
  endtask

  task automatic doRead(input logic [ADDR_W-2:0] a, input logic [DATA_W-1:0] expect_val);
    logic [DATA_W-1:0] r;
    logic [ADDR_W-1:0] fa;
    fa = ADDR_W'(a) | (ADDR_W'(1) << READ_FLAG_BIT);
    exp_rd.push_back(expect_val);
    applyStimulus(fa, '0, DUMMY_N, DATA_W, 1'b1, r);
    rd_got.push_back(r);
  endtask

  // Register-bank model: answers bus_re after rv_delay cycles unless withheld.
  initial begin
    logic [ADDR_W-2:0] a;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (bus_if.bus_re === 1'b1 && !withhold) begin
        a = bus_if.bus_addr;
        repeat (rv_delay) @(posedge sys_clk);
        #1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = mem[a];
        @(posedge sys_clk); #1;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT strobes or the host returns a read word.
  initial begin
    we_exp_t           e;
    logic [DATA_W-1:0] g;
    forever begin
      @(negedge sys_clk);
      if (bus_if.bus_we === 1'b1) begin
        if (exp_we.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_we: got addr 0x%0h data 0x%0h, want no strobe",
                   bus_if.bus_addr, bus_if.bus_wdata);
        end else begin
          e = exp_we.pop_front();
          checkOutput("we_addr", 32'(bus_if.bus_addr), 32'(e.addr));
          checkOutput("we_data", 32'(bus_if.bus_wdata), 32'(e.data));
        end
        mem[bus_if.bus_addr] = bus_if.bus_wdata;
      end
      if (bus_if.bus_re === 1'b1) re_seen++;
      if (frame_err === 1'b1) err_seen++;
      if (rd_got.size() > 0) begin
        g = rd_got.pop_front();
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpected_rd: got 0x%0h, want no read", g);
        end else begin
          checkOutput("rd_data", 32'(g), 32'(exp_rd.pop_front()));
        end
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] pats [5];
    pats = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000, 16'h5555};
    for (int i = 0; i < 128; i++) mem[i] = '0;

    repeat (4) @(negedge sys_clk);
    checkOutput("rst_miso", 32'(spi_miso), 0);
    checkOutput("rst_we", 32'(bus_if.bus_we), 0);
    checkOutput("rst_re", 32'(bus_if.bus_re), 0);
    checkOutput("rst_addr", 32'(bus_if.bus_addr), 0);
    checkOutput("rst_wdata", 32'(bus_if.bus_wdata), 0);
    checkOutput("rst_err", 32'(frame_err), 0);
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);
`ifdef SPI_BRIDGE_ERR_CNT_EN
    checkOutput("err_cnt_init", 32'(err_cnt), 0);
`endif

    $display("[TB] write 0x00 <- 0xAAAA");
    doWrite(7'h00, 16'hAAAA);
    checkOutput("re_after_write", 32'(re_seen), 0);

    $display("[TB] read 0x00, bank holds 0x2A2A");
    mem[0] = 16'h2A2A;
    doRead(7'h00, 16'h2A2A);
    checkOutput("re_after_read", 32'(re_seen), 1);

    $display("[TB] walking patterns");
    for (int i = 0; i < 5; i++) begin
      doWrite(7'(8'h10 + i), pats[i]);
      doRead(7'(8'h10 + i), pats[i]);
    end
    checkOutput("err_none_yet", 32'(err_seen), 0);

    $display("[TB] read with rvalid withheld");
    withhold = 1'b1;
    doRead(7'h11, 16'h0000);
    withhold = 1'b0;
    repeat (4) @(negedge sys_clk);
    checkOutput("err_late_read", 32'(err_seen), 1);
`ifdef SPI_BRIDGE_ERR_CNT_EN
    checkOutput("err_cnt_one", 32'(err_cnt), 1);
`endif

    $display("[TB] write aborted after 10 data bits");
    applyStimulus(8'h05, 16'h1234, DUMMY_N, 10, 1'b1, r);
    repeat (4) @(negedge sys_clk);
    checkOutput("err_abort", 32'(err_seen), 2);
    doWrite(7'h05, 16'h1234);
    doRead(7'h05, 16'h1234);

    $display("[TB] reset during dummy phase");
    applyStimulus(8'h81, '0, 3, 0, 1'b0, r);
    @(negedge sys_clk); sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk); sys_rst = 1'b0;
    @(negedge sys_clk);
    checkOutput("mid_rst_miso", 32'(spi_miso), 0);
    checkOutput("mid_rst_addr", 32'(bus_if.bus_addr), 0);
    checkOutput("mid_rst_wdata", 32'(bus_if.bus_wdata), 0);
    checkOutput("mid_rst_err", 32'(frame_err), 0);
`ifdef SPI_BRIDGE_ERR_CNT_EN
    checkOutput("mid_rst_err_cnt", 32'(err_cnt), 0);
`endif
    spi_cs_n = 1'b1;
    repeat (10) @(negedge sys_clk);
    doWrite(7'h02, 16'hFFFF);
    checkOutput("err_after_rst", 32'(err_seen), 2);

    repeat (20) @(negedge sys_clk);
    checkOutput("we_queue_empty", 32'(exp_we.size()), 0);
    checkOutput("rd_queue_empty", 32'(exp_rd.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
